chunked_serial_adder: RTL and testbench

//  Parametrised multi-cycle adder/subtractor, successor to the 16-bit ripple-carry adder.

---
 rtl/chunked_serial_adder.sv | 145 ++++++++++++++
 tb/tb_chunked_serial_adder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
//   Multi-cycle adder/subtractor. It processes WIDTH-bit operands CHUNK bits
//   per clock and keeps the carry in a register between chunks. The result
//   appears WIDTH/CHUNK cycles after the operands are accepted.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     in_valid   operands/mode valid
//     in_ready   block can accept a new operation (state IDLE)
//     a, b       WIDTH-bit operands (unsigned or two's complement)
//     cin        carry-in (add) / borrow-in (sub)
//     sub        0: a+b+cin   1: a-b-cin
//     out_valid  result valid; held until accepted
//     out_ready  downstream accepts the result
//     sum        WIDTH-bit result
//     cout       carry-out; in sub mode 1 means no borrow
//     ovf        signed overflow of the WIDTH-bit operation
//     busy       chunk additions in progress (state CALC)
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N   = WIDTH / CHUNK;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bq_q;      // b, already inverted for subtraction
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             accept;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == CALC);
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)          state_d = CALC;
      CALC:    if (cnt_q == LAST)   state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // One CHUNK-wide add per cycle; this is the only carry chain in the block.
  always_comb begin
    a_chunk   = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    b_chunk   = bq_q[int'(cnt_q)*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  // NOTE: operand holding registers are deliberately not reset; they are
  // only read after a capture, so their power-up value never matters.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      bq_q <= sub ? ~b : b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            // Subtraction is a + ~b + ~cin, so the borrow-in is inverted too.
            carry_q <= sub ? ~cin : cin;
            cnt_q   <= '0;
          end
        end
        CALC: begin
          sum[int'(cnt_q)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q <= chunk_sum[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // The last chunk holds the MSB, so its top sum bit is sum[MSB].
            cout      <= chunk_sum[CHUNK];
            ovf       <= (a_q[MSB] == bq_q[MSB]) & (chunk_sum[CHUNK-1] != a_q[MSB]);
            out_valid <= 1'b1;
            cnt_q     <= '0;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Testbench for chunked_serial_adder. It instantiates four configurations
// (16/4, 32/8, 16/16, 8/1). A stimulus process issues operations and queues
// the expected results. A monitor compares each presented result against the
// head of that configuration's queue and checks the latency.
module tb_chunked_serial_adder;

  localparam int NCFG = 4;
  localparam int CFG_W [NCFG] = '{16, 32, 16, 8};
  localparam int CFG_C [NCFG] = '{4, 8, 16, 1};

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;   // cycle index of the accept edge
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [NCFG];
  logic        in_ready  [NCFG];
  logic [31:0] a_in      [NCFG];
  logic [31:0] b_in      [NCFG];
  logic        cin_in    [NCFG];
  logic        sub_in    [NCFG];
  logic        out_valid [NCFG];
  logic        out_ready [NCFG];
  logic [31:0] sum_w     [NCFG];
  logic        cout_o    [NCFG];
  logic        ovf_o     [NCFG];
  logic        busy_o    [NCFG];

  int   rdy_mode [NCFG] = '{default: 0};  // 0: ready, 1: random stalls, 2: stalled
  exp_t sb       [NCFG][$];
  logic seen     [NCFG] = '{default: 1'b0};
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = CFG_W[g];
    localparam int C = CFG_C[g];
    logic [W-1:0] sum_l;
    chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .a        (a_in[g][W-1:0]),
      .b        (b_in[g][W-1:0]),
      .cin      (cin_in[g]),
      .sub      (sub_in[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .sum      (sum_l),
      .cout     (cout_o[g]),
      .ovf      (ovf_o[g]),
      .busy     (busy_o[g])
    );
    assign sum_w[g] = 32'(sum_l);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic s);
    exp_t        e;
    longint      mask, full, sa, sbv, r;
    mask = (longint'(1) << w) - 1;
    if (!s) full = longint'(av) + longint'(bv) + longint'(ci);
    else    full = longint'(av) + (~longint'(bv) & mask) + longint'(!ci);
    e.sum  = 32'(full & mask);
    e.cout = ((full >> w) & 1) != 0;
    sa  = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
    sbv = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
    r   = s ? sa - sbv - longint'(ci) : sa + sbv + longint'(ci);
    e.ovf = (r > (longint'(1) << (w-1)) - 1) || (r < -(longint'(1) << (w-1)));
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t lit(input logic [31:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.acc = 0;
    return e;
  endfunction

  // Ready driver: sole writer of out_ready, updated 2 time units after the edge.
  initial begin
    for (int g = 0; g < NCFG; g++) out_ready[g] = 1'b1;
    forever begin
      @(posedge clk); #2;
      for (int g = 0; g < NCFG; g++) begin
        case (rdy_mode[g])
          0:       out_ready[g] = 1'b1;
          1:       out_ready[g] = ($urandom_range(0, 2) != 0);
          default: out_ready[g] = 1'b0;
        endcase
      end
    end
  end

  // Monitor: compares the presented result against the scoreboard every cycle
  // out_valid is high (which covers stability during stalls) and pops on accept.
  always @(negedge clk) begin
    for (int g = 0; g < NCFG; g++) begin
      if (!rst && out_valid[g]) begin
        if (sb[g].size() == 0) begin
          check($sformatf("cfg%0d_spurious_out_valid", g), 64'(out_valid[g]), 64'd0);
        end else begin
          mon_e = sb[g][0];
          if (!seen[g]) begin
            seen[g] = 1'b1;
            check($sformatf("cfg%0d_latency", g), 64'(cyc - mon_e.acc),
                  64'(CFG_W[g] / CFG_C[g]));
          end
          check($sformatf("cfg%0d_sum", g),  64'(sum_w[g]),  64'(mon_e.sum));
          check($sformatf("cfg%0d_cout", g), 64'(cout_o[g]), 64'(mon_e.cout));
          check($sformatf("cfg%0d_ovf", g),  64'(ovf_o[g]),  64'(mon_e.ovf));
          if (out_ready[g]) begin
            void'(sb[g].pop_front());
            seen[g] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int g, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic s, input exp_t e);
    logic rdy;
    logic ok;
    ok = 1'b0;
    a_in[g] = av; b_in[g] = bv; cin_in[g] = ci; sub_in[g] = s;
    in_valid[g] = 1'b1;
    for (int t = 0; t < 500; t++) begin
      rdy = in_ready[g];
      tick();
      if (rdy) begin ok = 1'b1; break; end
    end
    in_valid[g] = 1'b0;
    if (!ok) begin
      check($sformatf("cfg%0d_accept_timeout", g), 64'(ok), 64'd1);
    end else begin
      e.acc = cyc;
      sb[g].push_back(e);
    end
  endtask

  task automatic drain();
    int pending;
    for (int t = 0; t < 3000; t++) begin
      pending = 0;
      for (int g = 0; g < NCFG; g++) pending += sb[g].size();
      if (pending == 0) break;
      tick();
    end
    pending = 0;
    for (int g = 0; g < NCFG; g++) pending += sb[g].size();
    check("drain_pending_results", 64'(pending), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] av, bv, mask, snap;
    logic        ci, s;
    int          w;

    void'($urandom(32'd20240611));
    for (int g = 0; g < NCFG; g++) begin
      in_valid[g] = 1'b0; a_in[g] = '0; b_in[g] = '0; cin_in[g] = 1'b0; sub_in[g] = 1'b0;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_sum",       64'(sum_w[0]),     64'd0);
    check("rst_cout",      64'(cout_o[0]),    64'd0);
    check("rst_ovf",       64'(ovf_o[0]),     64'd0);
    check("rst_busy",      64'(busy_o[0]),    64'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
    tick();

    // Directed add/sub vectors on 16/4
    issue(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, lit(32'h0000, 1'b1, 1'b0));
    drain();
    issue(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, lit(32'h8000, 1'b0, 1'b1));
    issue(0, 32'h1234, 32'h4321, 1'b1, 1'b0, lit(32'h5556, 1'b0, 1'b0));
    issue(0, 32'h0005, 32'h0007, 1'b0, 1'b1, lit(32'hFFFE, 1'b0, 1'b0));
    issue(0, 32'h8000, 32'h0001, 1'b0, 1'b1, lit(32'h7FFF, 1'b1, 1'b1));
    drain();

    // Backpressure: result held 5 cycles, inputs ignored while busy/done
    rdy_mode[0] = 2;
    tick();
    issue(0, 32'h00F0, 32'h0F0F, 1'b1, 1'b0, model(16, 32'h00F0, 32'h0F0F, 1'b1, 1'b0));
    check("bp_busy_in_calc", 64'(busy_o[0]), 64'd1);
    a_in[0] = 32'hDEAD; b_in[0] = 32'hBEEF; sub_in[0] = 1'b1;
    in_valid[0] = 1'b1;
    for (int t = 0; t < 50 && !out_valid[0]; t++) tick();
    check("bp_out_valid_seen", 64'(out_valid[0]), 64'd1);
    snap = sum_w[0];
    for (int t = 0; t < 5; t++) begin
      check("bp_out_valid_held", 64'(out_valid[0]), 64'd1);
      check("bp_in_ready_low",   64'(in_ready[0]),  64'd0);
      check("bp_sum_stable",     64'(sum_w[0]),     64'(snap));
      tick();
    end
    in_valid[0] = 1'b0;
    rdy_mode[0] = 0;
    tick();
    check("bp_release_out_valid", 64'(out_valid[0]), 64'd0);
    check("bp_release_in_ready",  64'(in_ready[0]),  64'd1);
    repeat (6) tick();

    // Reset two cycles into CALC aborts the operation
    issue(0, 32'h1111, 32'h2222, 1'b0, 1'b0, model(16, 32'h1111, 32'h2222, 1'b0, 1'b0));
    repeat (2) tick();
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid[0]), 64'd0);
    check("abort_sum",       64'(sum_w[0]),     64'd0);
    check("abort_cout",      64'(cout_o[0]),    64'd0);
    check("abort_ovf",       64'(ovf_o[0]),     64'd0);
    check("abort_busy",      64'(busy_o[0]),    64'd0);
    sb[0].delete();
    seen[0] = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();
    check("abort_in_ready", 64'(in_ready[0]), 64'd1);
    repeat (8) tick();
    check("abort_no_stale_valid", 64'(out_valid[0]), 64'd0);

    // Random sweep over all configurations with random stalls
    for (int g = 0; g < NCFG; g++) begin
      w = CFG_W[g];
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      rdy_mode[g] = 1;
      for (int i = 0; i < 10; i++) begin
        av = $urandom() & mask;
        bv = $urandom() & mask;
        ci = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        issue(g, av, bv, ci, s, model(w, av, bv, ci, s));
        repeat ($urandom_range(0, 2)) tick();
      end
      drain();
      rdy_mode[g] = 0;
    end

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
